mpt_request_issuer: RTL and testbench
=====================================

Name: mpt_request_issuer

Overview:
Transmitting end of the MPT pipeline data port. Accepts checker requests (SPA, access type, MMPT register), builds a fresh mptw_transaction_t, tags it with a free ID and drives it into the first pipeline stage over the valid/ready data handshake. Retires IDs when completed transactions return from the pipeline tail and forwards a response to the requester. Provides a drain FSM for quiescing before MMPT reconfiguration.

Parameters:
PIPELINE_MASTER_DATA_WIDTH, 32, width of the packed mptw_transaction_t driven on the master port; must equal $bits(mptw_transaction_t).
MAX_OUTSTANDING, 8, number of IDs in flight; power of two, 2..16.
ID_WIDTH, 4, width of the id field; must satisfy 2**ID_WIDTH >= MAX_OUTSTANDING.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid && ready
req_spa_i  in  spa_t_u  supervisor physical address
req_access_type_i  in  access_type_e  access type
req_mmpt_i  in  mmpt_reg_t  MMPT register snapshot
stage_master_data  out  PIPELINE_MASTER_DATA_WIDTH  transaction to first stage
stage_master_valid  out  1  transaction valid
stage_master_ready  in  1  first stage ready
cpl_valid_i  in  1  completed transaction from pipeline tail
cpl_ready_o  out  1  completion accepted
cpl_data_i  in  PIPELINE_MASTER_DATA_WIDTH  completed mptw_transaction_t
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  requester ready
rsp_id_o  out  ID_WIDTH  id of responded transaction
rsp_format_error_o  out  page_format_fault_e  format error
rsp_access_error_o  out  1  access error
drain_i  in  1  stop accepting, wait for zero outstanding
drained_o  out  1  drain complete
outstanding_o  out  ID_WIDTH+1  IDs currently busy
spurious_cpl_o  out  1  sticky: completion for non-busy ID

Behaviour:
- Reset (async, rst_i=1): stage_master_valid=0, rsp_valid_o=0, busy bitmap all 0, outstanding_o=0, spurious_cpl_o=0, FSM=RUN, drained_o=0, stage_master_data='0.
- Output register: single stage. On request acceptance the register loads valid=1, completed=0, id=lowest free ID, mmpt, spa, access_type, rpa='0, mpte='0, plb_hit=0, walking=MPT_WALKING_DO, format_error=NO_ERROR, access_error='0. Latency request-accept to stage_master_valid: 1 cycle.
- Data and valid held stable while stage_master_valid && !stage_master_ready; valid drops after the handshake unless a new request is loaded in the same cycle (back-to-back throughput 1/cycle).
- req_ready_o = (FSM==RUN) && free ID exists && (!stage_master_valid || stage_master_ready). Combinational, never depends on req_valid_i.
- ID allocation: priority encoder, lowest-index free bit among the low MAX_OUTSTANDING bits; busy bit set on accept.
- Completion: cpl_ready_o = !rsp_valid_o || rsp_ready_i. On cpl handshake: busy[id] cleared and response register loaded (id, format_error, access_error!=0); rsp_valid_o rises 1 cycle later. ID freed on handshake is allocatable the next cycle, never the same cycle.
- Simultaneous alloc and free in one cycle: outstanding_o unchanged; set and clear always target different IDs.
- Completion with busy[id]=0 or id>=MAX_OUTSTANDING: spurious_cpl_o set (sticky until reset), busy bitmap untouched, response still produced.
- FSM: RUN -> DRAIN when drain_i=1. DRAIN -> DRAINED when outstanding_o==0 && !stage_master_valid. DRAINED -> RUN when drain_i=0. DRAIN -> RUN if drain_i drops before completion. drained_o=1 only in DRAINED. Request accept is blocked in DRAIN and DRAINED. A request already in the output register still issues.
- Mid-operation reset discards everything; in-flight completions after reset count as spurious.

Decomposition:
- mpt_pkg adds mpt_issuer_state_e {ISSUER_RUN, ISSUER_DRAIN, ISSUER_DRAINED} and the MPT_MAX_OUTSTANDING default constant. Existing mptw_transaction_t, spa_t_u, mmpt_reg_t, page_format_fault_e, access_type_e and the walking enums are reused.
- One sub-module: mpt_id_allocator (busy bitmap, lowest-free encoder, set/clear, popcount for outstanding).
- Ports use the pipelining.svh master data port macro.

Test Plan:
- Reset, then one request spa=0x1000, mode SMMPT43, stage_master_ready=1 -> next cycle valid=1, id=0, walking=DO; outstanding_o=1.
- stage_master_ready=0 for 5 cycles after issue -> data/valid stable all 5 cycles; req_ready_o=0; issue on cycle 6.
- MAX_OUTSTANDING=8 back-to-back requests, no completions -> ids 0..7 issued, 9th request stalled with req_ready_o=0, outstanding_o=8. Complete id 3 -> next request gets id 3 one cycle later.
- Completion id=5 with format_error=NOT_VALID_ADDR, rsp_ready_i=0 for 3 cycles -> rsp held; cpl_ready_o=0 while the response is held; a completion for id 6 waits.
- drain_i=1 with 2 outstanding -> req_ready_o=0, drained_o=0 until both complete, then drained_o=1. drain_i=0 -> RUN, requests accepted.
- Completion for non-busy id 7 -> spurious_cpl_o=1 persists; outstanding_o unchanged. rst_i pulse clears it.

Source files
------------

// File: rtl/mpt_pkg.sv
// MPT shared types: transaction bundle, request fields, fault enums
// and the request-issuer drain FSM states.
package mpt_pkg;

  localparam int MPT_MAX_OUTSTANDING = 8;
  localparam int MPT_ID_W            = 4;
  localparam int MPT_SPA_W           = 13;

  typedef enum logic [1:0] {
    ACCESS_READ,
    ACCESS_WRITE,
    ACCESS_EXEC
  } access_type_e;

  typedef enum logic [1:0] {
    MMPT_BARE,
    MMPT_SMMPT34,
    MMPT_SMMPT43,
    MMPT_SMMPT52
  } mmpt_mode_e;

  typedef struct packed {
    mmpt_mode_e mode;
    logic [0:0] ppn;
  } mmpt_reg_t;

  typedef union packed {
    logic [MPT_SPA_W-1:0] raw;
    struct packed {
      logic [0:0]  vpn;
      logic [11:0] offset;
    } f;
  } spa_t_u;

  typedef enum logic [1:0] {
    NO_ERROR,
    NOT_VALID_ADDR,
    RESERVED_BITS,
    MISCONFIGURED
  } page_format_fault_e;

  typedef enum logic {
    MPT_WALKING_DO,
    MPT_WALKING_DONE
  } mpt_walking_e;

  typedef enum logic [1:0] {
    ISSUER_RUN,
    ISSUER_DRAIN,
    ISSUER_DRAINED
  } mpt_issuer_state_e;

  // 32 bits total; matches the default pipeline data width.
  typedef struct packed {
    logic               valid;
    logic               completed;
    logic [MPT_ID_W-1:0] id;
    mmpt_reg_t          mmpt;
    spa_t_u             spa;
    access_type_e       access_type;
    logic [1:0]         rpa;
    logic [0:0]         mpte;
    logic               plb_hit;
    mpt_walking_e       walking;
    page_format_fault_e format_error;
    logic [0:0]         access_error;
  } mptw_transaction_t;

endpackage

// File: rtl/mpt_id_allocator.sv
// Busy bitmap for in-flight IDs: lowest-free encoder, set/clear, popcount.
// Ports: i_alloc/o_free/o_free_id allocate; i_clr/i_clr_id/o_hit retire.
module mpt_id_allocator #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_WIDTH        = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_alloc,
  input  logic                i_clr,
  input  logic [ID_WIDTH-1:0] i_clr_id,
  output logic                o_free,
  output logic [ID_WIDTH-1:0] o_free_id,
  output logic                o_hit,
  output logic [ID_WIDTH:0]   o_outstanding
);

  logic [MAX_OUTSTANDING-1:0] r_busy;
  logic [MAX_OUTSTANDING-1:0] w_set;
  logic [MAX_OUTSTANDING-1:0] w_clr;

  // Descending scan so the lowest free index wins.
  always_comb begin
    o_free        = 1'b0;
    o_free_id     = '0;
    o_hit         = 1'b0;
    o_outstanding = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        o_free    = 1'b1;
        o_free_id = ID_WIDTH'(i);
      end
    end
    // Out-of-range IDs never match, so they read as not busy.
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (r_busy[i] && i_clr_id == ID_WIDTH'(i)) o_hit = 1'b1;
      o_outstanding = o_outstanding + (ID_WIDTH+1)'(r_busy[i]);
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      w_set[i] = i_alloc && o_free && (o_free_id == ID_WIDTH'(i));
      w_clr[i] = i_clr && r_busy[i] && (i_clr_id == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr) | w_set;
  end

endmodule

// File: rtl/mpt_request_issuer.sv
// Issues checker requests as tagged MPT transactions, retires IDs on
// completion, returns responses, and quiesces on drain_i.
module mpt_request_issuer
  import mpt_pkg::*;
#(
  parameter int PIPELINE_MASTER_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING            = MPT_MAX_OUTSTANDING,
  parameter int ID_WIDTH                   = MPT_ID_W
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  spa_t_u                                req_spa_i,
  input  access_type_e                          req_access_type_i,
  input  mmpt_reg_t                             req_mmpt_i,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  input  logic                                  cpl_valid_i,
  output logic                                  cpl_ready_o,
  input  logic [PIPELINE_MASTER_DATA_WIDTH-1:0] cpl_data_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [ID_WIDTH-1:0]                   rsp_id_o,
  output page_format_fault_e                    rsp_format_error_o,
  output logic                                  rsp_access_error_o,
  input  logic                                  drain_i,
  output logic                                  drained_o,
  output logic [ID_WIDTH:0]                     outstanding_o,
  output logic                                  spurious_cpl_o
);

  mptw_transaction_t  r_data;
  mptw_transaction_t  w_new;
  mptw_transaction_t  w_cpl_tr;
  logic               r_valid;
  logic               r_rsp_valid;
  logic [ID_WIDTH-1:0] r_rsp_id;
  page_format_fault_e r_rsp_fmt;
  logic               r_rsp_acc;
  logic               r_spur;
  mpt_issuer_state_e  r_state;
  mpt_issuer_state_e  w_state_nx;
  logic               w_free;
  logic [ID_WIDTH-1:0] w_free_id;
  logic               w_hit;
  logic [ID_WIDTH:0]  w_outstanding;
  logic               w_alloc;
  logic               w_cpl_hs;
  logic               w_unused;

  assign w_cpl_tr = mptw_transaction_t'(cpl_data_i);

  assign req_ready_o = (r_state == ISSUER_RUN) && w_free &&
                       (!r_valid || stage_master_ready);
  assign w_alloc     = req_valid_i && req_ready_o;
  assign cpl_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_cpl_hs    = cpl_valid_i && cpl_ready_o;

  mpt_id_allocator #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .ID_WIDTH       (ID_WIDTH)
  ) u_alloc (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_alloc      (w_alloc),
    .i_clr        (w_cpl_hs),
    .i_clr_id     (ID_WIDTH'(w_cpl_tr.id)),
    .o_free       (w_free),
    .o_free_id    (w_free_id),
    .o_hit        (w_hit),
    .o_outstanding(w_outstanding)
  );

  always_comb begin
    w_new              = '0;
    w_new.valid        = 1'b1;
    w_new.id           = MPT_ID_W'(w_free_id);
    w_new.mmpt         = req_mmpt_i;
    w_new.spa          = req_spa_i;
    w_new.access_type  = req_access_type_i;
    w_new.walking      = MPT_WALKING_DO;
    w_new.format_error = NO_ERROR;
  end

  // Reload on accept wins over drop, giving 1/cycle back-to-back.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_alloc) begin
      r_data  <= w_new;
      r_valid <= 1'b1;
    end else if (r_valid && stage_master_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_fmt   <= NO_ERROR;
      r_rsp_acc   <= 1'b0;
      r_spur      <= 1'b0;
    end else begin
      if (w_cpl_hs) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= ID_WIDTH'(w_cpl_tr.id);
        r_rsp_fmt   <= w_cpl_tr.format_error;
        r_rsp_acc   <= |w_cpl_tr.access_error;
        if (!w_hit) r_spur <= 1'b1;
      end else if (rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ISSUER_RUN;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    drained_o  = 1'b0;
    unique case (r_state)
      ISSUER_RUN: begin
        if (drain_i) w_state_nx = ISSUER_DRAIN;
      end
      ISSUER_DRAIN: begin
        if (!drain_i)
          w_state_nx = ISSUER_RUN;
        else if (w_outstanding == '0 && !r_valid)
          w_state_nx = ISSUER_DRAINED;
      end
      ISSUER_DRAINED: begin
        drained_o = 1'b1;
        if (!drain_i) w_state_nx = ISSUER_RUN;
      end
      default: w_state_nx = ISSUER_RUN;
    endcase
  end

  assign stage_master_data  = r_data;
  assign stage_master_valid = r_valid;
  assign rsp_valid_o        = r_rsp_valid;
  assign rsp_id_o           = r_rsp_id;
  assign rsp_format_error_o = r_rsp_fmt;
  assign rsp_access_error_o = r_rsp_acc;
  assign outstanding_o      = w_outstanding;
  assign spurious_cpl_o     = r_spur;

  assign w_unused = ^{w_cpl_tr.valid, w_cpl_tr.completed, w_cpl_tr.mmpt,
                      w_cpl_tr.spa, w_cpl_tr.access_type, w_cpl_tr.rpa,
                      w_cpl_tr.mpte, w_cpl_tr.plb_hit, w_cpl_tr.walking};

endmodule

// File: tb/tb_mpt_request_issuer.sv
// Bench for mpt_request_issuer: directed scenarios then random traffic,
// all checked against a transaction-level reference model.
module tb_mpt_request_issuer;
  import mpt_pkg::*;

  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               req_valid = 0;
  logic               req_ready;
  spa_t_u             req_spa = '0;
  access_type_e       req_at = ACCESS_READ;
  mmpt_reg_t          req_mmpt = '0;
  logic [31:0]        smd;
  logic               smv;
  logic               smr = 1;
  logic               cpl_valid = 0;
  logic               cpl_ready;
  logic [31:0]        cpl_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1;
  logic [3:0]         rsp_id;
  page_format_fault_e rsp_fmt;
  logic               rsp_acc;
  logic               drain = 0;
  logic               drained;
  logic [4:0]         outst;
  logic               spur;

  mptw_transaction_t so;
  assign so = mptw_transaction_t'(smd);

  mpt_request_issuer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_spa_i(req_spa), .req_access_type_i(req_at),
    .req_mmpt_i(req_mmpt),
    .stage_master_data(smd), .stage_master_valid(smv),
    .stage_master_ready(smr),
    .cpl_valid_i(cpl_valid), .cpl_ready_o(cpl_ready),
    .cpl_data_i(cpl_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_format_error_o(rsp_fmt),
    .rsp_access_error_o(rsp_acc),
    .drain_i(drain), .drained_o(drained),
    .outstanding_o(outst), .spurious_cpl_o(spur)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: set of busy IDs, pending output transaction,
  // pending response, sticky flag, drain mode (0 run, 1 wait, 2 done).
  bit                 mb [16];
  bit                 mout;
  mptw_transaction_t  mtr;
  bit                 mrsp;
  int                 mrid;
  page_format_fault_e mrfmt;
  bit                 mracc;
  bit                 mspur;
  int                 mmode;
  int                 inflight [$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < MAXO; i++) if (!mb[i]) return i;
    return -1;
  endfunction

  function automatic int busy_cnt();
    int c = 0;
    for (int i = 0; i < MAXO; i++) c += int'(mb[i]);
    return c;
  endfunction

  function automatic mptw_transaction_t mk_tr(int id, logic [12:0] spa,
      access_type_e at, mmpt_reg_t m);
    mptw_transaction_t t;
    t              = '0;
    t.valid        = 1'b1;
    t.id           = 4'(id);
    t.mmpt         = m;
    t.spa.raw      = spa;
    t.access_type  = at;
    t.walking      = MPT_WALKING_DO;
    t.format_error = NO_ERROR;
    return t;
  endfunction

  function automatic logic [31:0] mk_cpl(int id, page_format_fault_e f,
      bit a);
    mptw_transaction_t t;
    t              = mk_tr(id, 13'h0, ACCESS_READ, mmpt_reg_t'('0));
    t.completed    = 1'b1;
    t.walking      = MPT_WALKING_DONE;
    t.format_error = f;
    t.access_error = a;
    return t;
  endfunction

  task automatic model_reset();
    foreach (mb[i]) mb[i] = 0;
    mout = 0; mtr = '0; mrsp = 0; mspur = 0; mmode = 0;
    inflight.delete();
  endtask

  task automatic check_regs();
    chk("stage_valid", smv, mout);
    chk("stage_data", smd, mtr);
    chk("rsp_valid", rsp_valid, mrsp);
    if (mrsp) begin
      chk("rsp_id", rsp_id, mrid);
      chk("rsp_fmt", rsp_fmt, mrfmt);
      chk("rsp_acc", rsp_acc, mracc);
    end
    chk("outstanding", outst, busy_cnt());
    chk("spurious", spur, mspur);
    chk("drained", drained, mmode == 2);
  endtask

  // One clock: inputs already driven by the caller.
  task automatic cyc();
    bit er, ec, acc, hso, chs, oldout;
    int fid, c0;
    mptw_transaction_t ct;
    #1;
    er = (mmode == 0) && (lowest_free() >= 0) && (!mout || smr);
    ec = !mrsp || rsp_ready;
    chk("req_ready", req_ready, er);
    chk("cpl_ready", cpl_ready, ec);
    acc = req_valid && er;
    hso = mout && smr;
    chs = cpl_valid && ec;
    fid = lowest_free();
    c0 = busy_cnt();
    oldout = mout;
    @(posedge clk);
    if (hso) inflight.push_back(int'(mtr.id));
    if (chs) begin
      ct = mptw_transaction_t'(cpl_data);
      if (ct.id < MAXO && mb[ct.id]) begin
        mb[ct.id] = 0;
        for (int j = 0; j < inflight.size(); j++)
          if (inflight[j] == int'(ct.id)) begin
            inflight.delete(j);
            break;
          end
      end else mspur = 1;
      mrsp = 1; mrid = int'(ct.id);
      mrfmt = ct.format_error; mracc = ct.access_error != 0;
    end else if (rsp_ready) mrsp = 0;
    if (acc) begin
      mb[fid] = 1; mout = 1;
      mtr = mk_tr(fid, req_spa.raw, req_at, req_mmpt);
    end else if (hso) mout = 0;
    case (mmode)
      0: if (drain) mmode = 1;
      1: if (!drain) mmode = 0;
         else if (c0 == 0 && !oldout) mmode = 2;
      default: if (!drain) mmode = 0;
    endcase
    #1;
    check_regs();
  endtask

  task automatic reset_pulse();
    rst = 1;
    #2;
    model_reset();
    chk("rst_valid", smv, 0);
    chk("rst_data", smd, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_outst", outst, 0);
    chk("rst_spur", spur, 0);
    chk("rst_drained", drained, 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic do_cpl(int id, page_format_fault_e f, bit a);
    cpl_data = mk_cpl(id, f, a);
    cpl_valid = 1;
    cyc();
    cpl_valid = 0;
  endtask

  logic [31:0] hold;

  initial begin
    model_reset();
    #3;
    reset_pulse();

    // Single issue
    req_valid = 1; req_spa.raw = 13'h1000; req_at = ACCESS_READ;
    req_mmpt.mode = MMPT_SMMPT43; req_mmpt.ppn = 1'b1;
    cyc();
    req_valid = 0;
    chk("t1_valid", smv, 1);
    chk("t1_id", so.id, 0);
    chk("t1_spa", so.spa.raw, 13'h1000);
    chk("t1_walk", so.walking, MPT_WALKING_DO);
    chk("t1_outst", outst, 1);
    cyc();
    chk("t1_drop", smv, 0);
    do_cpl(0, NO_ERROR, 0);
    chk("t1_rsp_id", rsp_id, 0);

    // Stalled first stage
    smr = 0; req_valid = 1; req_spa.raw = 13'h0abc; req_at = ACCESS_WRITE;
    cyc();
    hold = smd;
    req_spa.raw = 13'h1555;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_hold", smd, hold);
      chk("t2_valid", smv, 1);
      chk("t2_rdy", req_ready, 0);
    end
    req_valid = 0; smr = 1;
    cyc();
    chk("t2_issued", smv, 0);
    do_cpl(0, NO_ERROR, 0);

    // Fill all IDs back-to-back
    req_valid = 1;
    for (int k = 0; k < MAXO; k++) begin
      req_spa.raw = 13'($urandom);
      cyc();
      chk("t3_id", so.id, k);
    end
    chk("t3_full", outst, 8);
    chk("t3_rdy", req_ready, 0);
    cyc();
    cyc();
    do_cpl(3, NO_ERROR, 0);
    chk("t3_rdy_again", req_ready, 1);
    cyc();
    chk("t3_reuse", so.id, 3);
    req_valid = 0;
    cyc();

    // Response back-pressure
    rsp_ready = 0;
    do_cpl(5, NOT_VALID_ADDR, 0);
    chk("t4_fmt", rsp_fmt, NOT_VALID_ADDR);
    cpl_data = mk_cpl(6, NO_ERROR, 1);
    cpl_valid = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_hold_id", rsp_id, 5);
      chk("t4_cpl_rdy", cpl_ready, 0);
    end
    rsp_ready = 1;
    cyc();
    cpl_valid = 0;
    chk("t4_next_id", rsp_id, 6);
    chk("t4_acc", rsp_acc, 1);
    cyc();
    chk("t4_outst", outst, 6);

    // Drain with two outstanding
    for (int k = 0; k < 4; k++) do_cpl(k, NO_ERROR, 0);
    chk("t5_outst", outst, 2);
    drain = 1;
    cyc();
    chk("t5_rdy", req_ready, 0);
    req_valid = 1;
    cyc();
    chk("t5_blocked", outst, 2);
    do_cpl(4, NO_ERROR, 0);
    chk("t5_not_yet", drained, 0);
    do_cpl(7, NO_ERROR, 0);
    chk("t5_not_yet2", drained, 0);
    cyc();
    chk("t5_drained", drained, 1);
    drain = 0;
    cyc();
    chk("t5_run", req_ready, 1);
    cyc();
    chk("t5_issue", so.id, 0);
    req_valid = 0;
    cyc();

    // Spurious completions
    do_cpl(7, NO_ERROR, 0);
    chk("t6_spur", spur, 1);
    chk("t6_outst", outst, 1);
    do_cpl(12, RESERVED_BITS, 0);
    chk("t6_rsp_id", rsp_id, 12);
    for (int k = 0; k < 3; k++) cyc();
    chk("t6_sticky", spur, 1);
    reset_pulse();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      req_valid = $urandom_range(0, 2) != 0;
      req_spa.raw = 13'($urandom);
      req_at = access_type_e'(2'($urandom_range(0, 2)));
      req_mmpt.mode = mmpt_mode_e'(2'($urandom_range(0, 3)));
      req_mmpt.ppn = 1'($urandom);
      smr = $urandom_range(0, 3) != 0;
      rsp_ready = $urandom_range(0, 3) != 0;
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        cpl_data = mk_cpl(inflight[$urandom_range(0, inflight.size() - 1)],
                          page_format_fault_e'(2'($urandom_range(0, 3))),
                          1'($urandom));
        cpl_valid = 1;
      end else if ($urandom_range(0, 60) == 0) begin
        cpl_data = mk_cpl($urandom_range(0, 15), NO_ERROR, 0);
        cpl_valid = 1;
      end else cpl_valid = 0;
      if ($urandom_range(0, 30) == 0) drain = ~drain;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
